key_iv_slot_loader: RTL and testbench
=====================================

// Module: key_iv_slot_loader
// PURPOSE
//  Parametrised key/IV store for the CS-PCNG cipher core. Key/IV frames stream in over a
//  valid/ready word interface into one of NUM_SLOTS slots. A read selects a slot and drives
//  key_o/iv_o to the cipher. Unwritten slots read back the built-in DEFAULT_KEY/DEFAULT_IV.
//  zeroize wipes all key material.
// PARAMETERS
//  KEY_W        147         key width, bits
//  IV_W         32          IV width, bits
//  IN_W         32          load beat width; WORDS = ceil((KEY_W+IV_W)/IN_W), must be >= 2
//  NUM_SLOTS    4           number of key/IV slots, >= 1; SLOT_W = max(1,clog2(NUM_SLOTS))
//  DEFAULT_KEY  legacy 147b default key constant
//  DEFAULT_IV   32'hC33C_B332  default IV
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       synchronous, active-high
//  zeroize      in   1       wipe all slots and outputs
//  load_valid   in   1       beat present
//  load_ready   out  1       block can accept beat
//  load_data    in   IN_W    beat data
//  load_slot    in   SLOT_W  target slot, sampled on first beat only
//  load_abort   in   1       discard partial frame
//  load_done    out  1       one-cycle commit strobe
//  load_err     out  1       one-cycle strobe: frame dropped, slot out of range
//  busy         out  1       FSM not IDLE
//  rd_en        in   1       read request
//  rd_slot      in   SLOT_W  slot to read
//  key_o        out  KEY_W   current key
//  iv_o         out  IV_W    current IV
//  out_valid    out  1       key_o/iv_o hold a read result
//  rd_default   out  1       last read returned defaults
// BEHAVIOUR
//  Reset/zeroize: all slot data 0, slot_vld 0, key_o/iv_o/out_valid/rd_default/load_done/
//   load_err 0, FSM to IDLE, beat count 0. Priority: reset > zeroize > all other inputs.
//  Frame: {key,iv} zero-extended at MSB to WORDS*IN_W bits; beat 0 carries the most
//   significant IN_W bits. Shift reg sr <= {sr, load_data}. key = sr[KEY_W+IV_W-1:IV_W],
//   iv = sr[IV_W-1:0]. Pad bits in beat 0 are ignored.
//  Accept = load_valid & load_ready at the clock edge.
//  FSM IDLE: load_ready=1. Accept -> latch slot, cnt=1, go LOAD.
//  FSM LOAD: load_ready=1. Accept -> cnt++. An accept with cnt==WORDS-1 goes to COMMIT.
//   load_abort (any cycle in LOAD, wins over a same-cycle beat) -> IDLE, nothing written.
//   load_abort in IDLE has no effect.
//  FSM COMMIT: load_ready=0, exactly 1 cycle. load_done=1 (or load_err=1 if slot >= NUM_SLOTS).
//   At the end of this cycle: slot written and slot_vld set; -> IDLE. The new data is
//   readable from the next cycle.
//  busy = (state != IDLE). Minimum frame = WORDS+1 cycles; no bubbles needed between frames.
//  Read: rd_en at edge t -> key_o/iv_o/rd_default valid after t (1-cycle latency).
//   out_valid=1 after the first read and stays set until reset/zeroize.
//   Outputs hold between reads.
//  Slot valid -> stored key/iv, rd_default=0. Slot invalid or out of range -> DEFAULT_KEY/IV,
//   rd_default=1.
//  Read of a slot in its COMMIT cycle returns pre-commit contents. Rewriting a slot overwrites it.
//  Loads and reads are independent; both may happen in the same cycle.
// TESTING
//  (Defaults: WORDS=6.)
//  1 Reset; rd_en slot 0 -> next cycle key_o=DEFAULT_KEY, iv_o=32'hC33CB332, rd_default=1,
//    out_valid=1.
//  2 Load slot 2 with beats 1..6 back-to-back -> load_done in 7th cycle; read slot 2 ->
//    iv_o=32'h6, key_o={19'h1,32'h2,32'h3,32'h4,32'h5}, rd_default=0.
//  3 Same frame with load_valid gaps and random stalls -> identical result; load_ready=0 only
//    in COMMIT.
//  4 After 3 beats assert load_abort -> no load_done; slot 2 keeps prior data; next frame
//    loads cleanly.
//  5 rd_en slot 2 in the COMMIT cycle of a new frame -> old data; read next cycle -> new data.
//  6 zeroize after loads -> key_o=0, iv_o=0, out_valid=0; reads of all slots return defaults.
//    Reset mid-frame -> same.

Source files
------------

// File: rtl/key_iv_slot_loader_if.sv
// Load/read bus for the key/IV slot store.
// The master modport drives loads and reads; the slave modport returns key material and status.
interface key_iv_slot_loader_if #(
  parameter int unsigned KEY_W  = 147,
  parameter int unsigned IV_W   = 32,
  parameter int unsigned IN_W   = 32,
  parameter int unsigned SLOT_W = 2
);
  logic              zeroize;
  logic              load_valid;
  logic              load_ready;
  logic [IN_W-1:0]   load_data;
  logic [SLOT_W-1:0] load_slot;
  logic              load_abort;
  logic              load_done;
  logic              load_err;
  logic              busy;
  logic              rd_en;
  logic [SLOT_W-1:0] rd_slot;
  logic [KEY_W-1:0]  key_o;
  logic [IV_W-1:0]   iv_o;
  logic              out_valid;
  logic              rd_default;

  modport master (
    output zeroize, load_valid, load_data, load_slot, load_abort, rd_en, rd_slot,
    input  load_ready, load_done, load_err, busy, key_o, iv_o, out_valid, rd_default
  );

  modport slave (
    input  zeroize, load_valid, load_data, load_slot, load_abort, rd_en, rd_slot,
    output load_ready, load_done, load_err, busy, key_o, iv_o, out_valid, rd_default
  );
endinterface

// File: rtl/key_iv_slot_loader.sv
// Key/IV slot store: streams {key,iv} frames into slots and serves a registered read port.
// Slots that were never written return the built-in default key/IV.
module key_iv_slot_loader #(
  parameter int unsigned      KEY_W       = 147,
  parameter int unsigned      IV_W        = 32,
  parameter int unsigned      IN_W        = 32,
  parameter int unsigned      NUM_SLOTS   = 4,
  parameter logic [KEY_W-1:0] DEFAULT_KEY = KEY_W'(147'h5_0123456789ABCDEF_FEDCBA9876543210_0F1E),
  parameter logic [IV_W-1:0]  DEFAULT_IV  = IV_W'(32'hC33C_B332)
) (
  input logic                 clk,
  input logic                 reset,
  key_iv_slot_loader_if.slave bus
);
  localparam int unsigned FRAME_W = KEY_W + IV_W;
  localparam int unsigned WORDS   = (FRAME_W + IN_W - 1) / IN_W;
  localparam int unsigned SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned CNT_W   = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SLOT_W-1:0]  r_slot;
  logic [FRAME_W-1:0] r_sr;
  logic [KEY_W-1:0]   r_key [NUM_SLOTS];
  logic [IV_W-1:0]    r_iv  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_vld;
  logic               r_load_done;
  logic               r_load_err;
  logic [KEY_W-1:0]   r_key_o;
  logic [IV_W-1:0]    r_iv_o;
  logic               r_out_valid;
  logic               r_rd_default;

  logic               w_accept;
  logic               w_slot_ok;
  logic [FRAME_W-1:0] w_sr_next;
  logic               w_rd_hit;
  logic [KEY_W-1:0]   w_rd_key;
  logic [IV_W-1:0]    w_rd_iv;

  assign bus.load_ready = (r_state != ST_COMMIT);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.load_done  = r_load_done;
  assign bus.load_err   = r_load_err;
  assign bus.key_o      = r_key_o;
  assign bus.iv_o       = r_iv_o;
  assign bus.out_valid  = r_out_valid;
  assign bus.rd_default = r_rd_default;

  assign w_accept  = bus.load_valid & bus.load_ready;
  assign w_slot_ok = (32'(r_slot) < NUM_SLOTS);
  // Pad bits of beat 0 fall off the top of the shift register.
  assign w_sr_next = FRAME_W'({r_sr, bus.load_data});

  // Read lookup; out-of-range or unwritten slots miss and fall back to defaults.
  always_comb begin
    w_rd_hit = 1'b0;
    w_rd_key = '0;
    w_rd_iv  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (SLOT_W'(i) == bus.rd_slot && r_vld[i]) begin
        w_rd_hit = 1'b1;
        w_rd_key = r_key[i];
        w_rd_iv  = r_iv[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.zeroize) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_slot       <= '0;
      r_sr         <= '0;
      r_vld        <= '0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_key_o      <= '0;
      r_iv_o       <= '0;
      r_out_valid  <= 1'b0;
      r_rd_default <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_key[i] <= '0;
        r_iv[i]  <= '0;
      end
    end else begin
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_slot  <= bus.load_slot;
            r_cnt   <= CNT_W'(1);
            r_sr    <= w_sr_next;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Abort beats a same-cycle beat.
          if (bus.load_abort) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            r_sr <= w_sr_next;
            if (r_cnt == CNT_W'(WORDS - 1)) begin
              r_cnt       <= '0;
              r_state     <= ST_COMMIT;
              r_load_done <= w_slot_ok;
              r_load_err  <= ~w_slot_ok;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_slot_ok && SLOT_W'(i) == r_slot) begin
              r_key[i] <= r_sr[FRAME_W-1:IV_W];
              r_iv[i]  <= r_sr[IV_W-1:0];
              r_vld[i] <= 1'b1;
            end
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Read port samples slot contents before any same-edge commit.
      if (bus.rd_en) begin
        r_out_valid  <= 1'b1;
        r_rd_default <= ~w_rd_hit;
        r_key_o      <= w_rd_hit ? w_rd_key : DEFAULT_KEY;
        r_iv_o       <= w_rd_hit ? w_rd_iv  : DEFAULT_IV;
      end
    end
  end
endmodule

// File: tb/tb_key_iv_slot_loader.sv
// Scoreboard bench for key_iv_slot_loader: drivers push expected strobes/read results,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_key_iv_slot_loader;
  localparam int unsigned KEY_W     = 147;
  localparam int unsigned IV_W      = 32;
  localparam int unsigned IN_W      = 32;
  localparam int unsigned NUM_SLOTS = 3;
  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned WORDS     = 6;

  localparam logic [KEY_W-1:0] DEF_KEY = 147'h5_0123456789ABCDEF_FEDCBA9876543210_0F1E;
  localparam logic [IV_W-1:0]  DEF_IV  = 32'hC33C_B332;
  localparam logic [KEY_W-1:0] A_KEY   = {19'h1, 32'h2, 32'h3, 32'h4, 32'h5};
  localparam logic [IV_W-1:0]  A_IV    = 32'h6;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [IV_W-1:0]  iv;
    logic             def;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [1:0] ev_q[$];
  rd_exp_t    mon_rd;
  logic [1:0] mon_ev;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rd_pend = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  key_iv_slot_loader_if #(.KEY_W(KEY_W), .IV_W(IV_W), .IN_W(IN_W), .SLOT_W(SLOT_W)) bus ();

  key_iv_slot_loader #(.KEY_W(KEY_W), .IV_W(IV_W), .IN_W(IN_W), .NUM_SLOTS(NUM_SLOTS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: strobes and read results are compared against the queues.
  always @(posedge clk) rd_pend <= bus.rd_en && !reset && !bus.zeroize;

  always @(negedge clk) begin
    if (!reset) begin
      check("ready_low_only_in_commit", KEY_W'(bus.load_ready), KEY_W'(!(bus.load_done || bus.load_err)));
      if (bus.load_done || bus.load_err) begin
        if (ev_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: done=%0b err=%0b required none", bus.load_done, bus.load_err);
        end else begin
          mon_ev = ev_q.pop_front();
          check("load_done", KEY_W'(bus.load_done), KEY_W'(mon_ev[1]));
          check("load_err", KEY_W'(bus.load_err), KEY_W'(mon_ev[0]));
        end
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_underflow: read result with no expectation");
        end else begin
          mon_rd = rd_q.pop_front();
          check("rd_key", bus.key_o, mon_rd.key);
          check("rd_iv", KEY_W'(bus.iv_o), KEY_W'(mon_rd.iv));
          check("rd_default", KEY_W'(bus.rd_default), KEY_W'(mon_rd.def));
          check("rd_out_valid", KEY_W'(bus.out_valid), KEY_W'(1'b1));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [IN_W-1:0] d, input logic [SLOT_W-1:0] slot);
    int t = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_slot  = slot;
    while (!bus.load_ready && t < 50) begin
      tick();
      t++;
    end
    if (!bus.load_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: load_ready=0 after %0d cycles, required 1", t);
    end
    tick();
    bus.load_valid = 1'b0;
    bus.load_data  = IN_W'($urandom);
    bus.load_slot  = SLOT_W'($urandom);
  endtask

  // Returns in the COMMIT cycle of the frame.
  task automatic send_frame(input logic [WORDS*IN_W-1:0] f, input logic [SLOT_W-1:0] slot,
                            input bit stall, input logic [1:0] exp_ev);
    for (int i = 0; i < WORDS; i++) begin
      if (stall) repeat ($urandom_range(0, 3)) tick();
      if (i == WORDS - 1) ev_q.push_back(exp_ev);
      send_beat(f[(WORDS-1-i)*IN_W +: IN_W], (i == 0) ? slot : SLOT_W'($urandom));
    end
  endtask

  task automatic rd(input logic [SLOT_W-1:0] s, input logic [KEY_W-1:0] k,
                    input logic [IV_W-1:0] v, input logic d);
    rd_q.push_back('{key: k, iv: v, def: d});
    bus.rd_en   = 1'b1;
    bus.rd_slot = s;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic rd_def(input logic [SLOT_W-1:0] s);
    rd(s, DEF_KEY, DEF_IV, 1'b1);
  endtask

  function automatic logic [KEY_W-1:0] key_of(input logic [WORDS*IN_W-1:0] f);
    return f[KEY_W+IV_W-1:IV_W];
  endfunction

  function automatic logic [IV_W-1:0] iv_of(input logic [WORDS*IN_W-1:0] f);
    return f[IV_W-1:0];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [WORDS*IN_W-1:0] fa, fc, fd, fe, ff, fg;
    fa = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    fc = {32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
    fd = {32'hFFFF_FFD0, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h5555_AAAA, 32'hD5D5_D5D5};
    fe = {32'h0000_0E00, 32'hE1E1_E1E1, 32'hE2E2_E2E2, 32'hE3E3_E3E3, 32'hE4E4_E4E4, 32'hE5E5_E5E5};
    ff = {32'h7, 32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5};
    fg = {32'h9, 32'h91, 32'h92, 32'h93, 32'h94, 32'h95};

    bus.zeroize = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_slot = '0;
    bus.load_abort = 1'b0; bus.rd_en = 1'b0; bus.rd_slot = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_key_o", bus.key_o, '0);
    check("reset_iv_o", KEY_W'(bus.iv_o), '0);
    check("reset_out_valid", KEY_W'(bus.out_valid), '0);
    check("reset_busy", KEY_W'(bus.busy), '0);
    check("reset_load_ready", KEY_W'(bus.load_ready), KEY_W'(1'b1));

    // Unwritten slot reads defaults.
    rd_def(2'd0);

    // Back-to-back frame: strobe in the 7th cycle, then read.
    send_frame(fa, 2'd2, 1'b0, 2'b10);
    check("commit_cycle_done", KEY_W'(bus.load_done), KEY_W'(1'b1));
    check("commit_cycle_busy", KEY_W'(bus.busy), KEY_W'(1'b1));
    tick();
    rd(2'd2, A_KEY, A_IV, 1'b0);
    rd_def(2'd1);

    // Same frame with gaps/stalls into slot 0.
    send_frame(fa, 2'd0, 1'b1, 2'b10);
    tick();
    rd(2'd0, A_KEY, A_IV, 1'b0);

    // Abort after 3 beats, with a same-cycle beat that must be dropped.
    for (int i = 0; i < 3; i++) send_beat(fc[(WORDS-1-i)*IN_W +: IN_W], 2'd2);
    bus.load_abort = 1'b1; bus.load_valid = 1'b1; bus.load_data = 32'hBAD0_BAD0;
    tick();
    bus.load_abort = 1'b0; bus.load_valid = 1'b0;
    check("abort_busy", KEY_W'(bus.busy), '0);
    rd(2'd2, A_KEY, A_IV, 1'b0);
    send_frame(fd, 2'd2, 1'b0, 2'b10);
    tick();
    rd(2'd2, key_of(fd), iv_of(fd), 1'b0);

    // Read in the COMMIT cycle returns old data, next read returns new.
    send_frame(fe, 2'd2, 1'b0, 2'b10);
    rd(2'd2, key_of(fd), iv_of(fd), 1'b0);
    rd(2'd2, key_of(fe), iv_of(fe), 1'b0);

    // Back-to-back frames, the second to an out-of-range slot.
    send_frame(ff, 2'd1, 1'b0, 2'b10);
    send_frame(fg, 2'd3, 1'b0, 2'b01);
    tick();
    rd(2'd1, key_of(ff), iv_of(ff), 1'b0);
    rd_def(2'd3);

    // Zeroize wipes outputs and slots.
    bus.zeroize = 1'b1;
    tick();
    bus.zeroize = 1'b0;
    check("zeroize_key_o", bus.key_o, '0);
    check("zeroize_iv_o", KEY_W'(bus.iv_o), '0);
    check("zeroize_out_valid", KEY_W'(bus.out_valid), '0);
    rd_def(2'd0);
    rd_def(2'd1);
    rd_def(2'd2);

    // Reset mid-frame after a completed load.
    send_frame(fa, 2'd0, 1'b0, 2'b10);
    tick();
    rd(2'd0, A_KEY, A_IV, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(fc[(WORDS-1-i)*IN_W +: IN_W], 2'd1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("reset_mid_key_o", bus.key_o, '0);
    check("reset_mid_iv_o", KEY_W'(bus.iv_o), '0);
    check("reset_mid_out_valid", KEY_W'(bus.out_valid), '0);
    check("reset_mid_busy", KEY_W'(bus.busy), '0);
    rd_def(2'd0);
    rd_def(2'd1);

    repeat (4) tick();
    check("strobe_queue_drained", KEY_W'(ev_q.size()), '0);
    check("read_queue_drained", KEY_W'(rd_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
